// File: rtl/seq_pkg.sv
// seq_pkg: shared defaults, types and helpers for the programmable
// sequence detector family.
package seq_pkg;

  localparam int          DEF_PAT_MAX     = 8;
  localparam logic [31:0] DEF_RST_PATTERN = 32'b0000_0110;
  localparam int          DEF_RST_LEN     = 3;
  localparam int          DEF_CNT_W       = 16;

  // Detection mode: whether bits of a matched window may start the next match.
  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } overlapMode_e;

  // Width needed to hold a pattern length from 0 up to patMax inclusive.
  function automatic int lenWidth(input int patMax);
    return $clog2(patMax + 1);
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// seq_window_cmp: combinational masked compare of the newest len bits of
// {hist, bit} against the low len bits of the programmed pattern.
module seq_window_cmp
  import seq_pkg::*;
#(
  parameter int PAT_MAX = DEF_PAT_MAX,
  parameter int LEN_W   = lenWidth(PAT_MAX)
) (
  input  logic [PAT_MAX-2:0] hist_i,
  input  logic               bit_i,
  input  logic [PAT_MAX-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               eq_o
);

  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] mask;

  // Keep only the newest len bits, then require them all to equal the pattern.
  always_comb begin
    window = {hist_i, bit_i};
    mask   = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len_i));
    end
    eq_o = (((window ^ pattern_i) & mask) == '0);
  end

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with
// Mealy (combinational) and Moore (registered) match outputs.
// Define SEQDET_CNT_EN to add the saturating match_cnt output.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter int                 PAT_MAX     = DEF_PAT_MAX,
  parameter logic [PAT_MAX-1:0] RST_PATTERN = PAT_MAX'(DEF_RST_PATTERN),
  parameter int                 RST_LEN     = DEF_RST_LEN,
  parameter int                 CNT_W       = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         cfg_load,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [lenWidth(PAT_MAX)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         y_mealy,
  output logic                         y_moore,
  output logic                         cfg_err
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0]             match_cnt
`endif
);

  localparam int               LEN_W    = lenWidth(PAT_MAX);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_MAX - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_MAX);

  logic [PAT_MAX-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_MAX-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  overlapMode_e       overlap_q, overlap_d;
  logic               y_moore_q;
  logic               cfg_err_q;

  logic               cfgLenOk;
  logic               loadAccept;
  logic               loadReject;
  logic               windowEq;
  logic               windowFilled;
  logic               match;
  logic [PAT_MAX-1:0] window;

  seq_window_cmp #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_window_cmp (
    .hist_i    (hist_q),
    .bit_i     (in),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .eq_o      (windowEq)
  );

  // Qualify the raw window compare: enough history, a valid bit, no accepted load, not in reset.
  always_comb begin
    cfgLenOk     = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    loadAccept   = cfg_load & cfgLenOk;
    loadReject   = cfg_load & ~cfgLenOk;
    window       = {hist_q, in};
    windowFilled = (fill_q >= (len_q - LEN_W'(1)));
    match        = rst_n & in_valid & ~loadAccept & windowFilled & windowEq;
  end

  // Next state: an accepted load swaps the configuration and empties the window, otherwise valid bits shift in.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    if (loadAccept) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap ? MODE_OVERLAP : MODE_NONOVERLAP;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = window[PAT_MAX-2:0];
      if (match && (overlap_q == MODE_NONOVERLAP)) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // Register detector state and the one-cycle Moore and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= MODE_OVERLAP;
      y_moore_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      y_moore_q <= match;
      cfg_err_q <= loadReject;
    end
  end

  assign y_mealy = match;
  assign y_moore = y_moore_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count matches, holding at all-ones; configuration loads never touch it.
  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Match counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  // CNT_W only sizes the optional counter; fold it into a sink so the parameter stays referenced.
  logic unusedCntW;
  assign unusedCntW = ^CNT_W;
`endif

endmodule
